// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard sequencer.
// State encodings and the load-use detect function live here so the pipeline registers and the sequencer use the same definitions.
package pipe_hazard_ctrl_pkg;

    typedef enum logic {
        S_RUN     = 1'b0,
        S_MD_WAIT = 1'b1
    } state_t;

    localparam int MD_CNT_W = 6;

    // A load into $0 can never create a dependency, so it must not stall.
    function automatic logic load_use_hit(
        input logic       memread,
        input logic [4:0] rd,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       uses_rs,
        input logic       uses_rt
    );
        return memread && (rd != 5'd0) &&
               ((uses_rs && (rd == rs)) || (uses_rt && (rd == rt)));
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_md_busy_timer.sv
// Loadable down-counter that tracks the remaining EX occupancy of a mult/div op.
// The done flag is high whenever the count has reached zero.
module md_busy_timer
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [MD_CNT_W-1:0] load_val,
    input  logic                en,
    output logic                done
);

    logic [MD_CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (en && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign done = (cnt_reg == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall sequencer for the 5-stage pipeline: load-use stalls, redirect flushes, mult/div EX occupancy.
// Mult/div sequencing is present only when PIPE_MD_STALL_EN is defined.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MD_CYCLES = 32,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    input  logic             md_start,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_stall,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    // The md_start cycle itself is the first stall cycle, so the timer covers the rest.
    localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_CYCLES - 2);

    state_t           state_reg;
    state_t           state_next;
    logic             load_use;
    logic [CNT_W-1:0] stall_cnt_reg;

    assign load_use = load_use_hit(ex_memread, ex_rd, id_rs, id_rt, id_uses_rs, id_uses_rt);

`ifdef PIPE_MD_STALL_EN
    logic md_load;
    logic md_done;

    md_busy_timer u_md_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (md_load),
        .load_val (MD_LOAD),
        .en       (state_reg == S_MD_WAIT),
        .done     (md_done)
    );
`else
    logic md_unused;
    assign md_unused = md_start | (|MD_LOAD);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_stall  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        md_busy     = 1'b0;
`ifdef PIPE_MD_STALL_EN
        md_load     = 1'b0;
`endif
        // Outputs are forced low for the whole time reset is held.
        if (rst) begin
            case (state_reg)
`ifdef PIPE_MD_STALL_EN
                S_MD_WAIT: begin
                    pc_stall    = 1'b1;
                    ifid_stall  = 1'b1;
                    idex_stall  = 1'b1;
                    exmem_flush = 1'b1;
                    md_busy     = 1'b1;
                    if (md_done) begin
                        state_next = S_RUN;
                    end
                end
`endif
                default: begin
                    if (ex_redirect) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end
`ifdef PIPE_MD_STALL_EN
                    else if (md_start) begin
                        md_load     = 1'b1;
                        state_next  = S_MD_WAIT;
                        pc_stall    = 1'b1;
                        ifid_stall  = 1'b1;
                        idex_stall  = 1'b1;
                        exmem_flush = 1'b1;
                        md_busy     = 1'b1;
                    end
`endif
                    else if (load_use) begin
                        pc_stall   = 1'b1;
                        ifid_stall = 1'b1;
                        idex_flush = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_reg <= '0;
        end else if (pc_stall && (stall_cnt_reg != '1)) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl; mult/div expectations follow PIPE_MD_STALL_EN.
// A second instance with a 4-bit counter covers stall-counter saturation.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  id_rs = '0, id_rt = '0, ex_rd = '0;
    logic        id_uses_rs = 1'b0, id_uses_rt = 1'b0;
    logic        ex_memread = 1'b0, ex_redirect = 1'b0, md_start = 1'b0;

    logic        pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_flush, md_busy;
    logic [15:0] stall_cnt;
    logic        s_pc_stall, s_ifid_stall, s_ifid_flush, s_idex_stall, s_idex_flush, s_exmem_flush, s_md_busy;
    logic [3:0]  s_stall_cnt;

    int n_chk = 0;
    int n_fail = 0;

    // {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_flush, md_busy}
    localparam logic [6:0] C_IDLE = 7'b0000000;
    localparam logic [6:0] C_LU   = 7'b1100100;
    localparam logic [6:0] C_RDR  = 7'b0010100;
    localparam logic [6:0] C_MD   = 7'b1101011;

    logic [6:0] ctrl;
    assign ctrl = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_flush, md_busy};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MD_CYCLES(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_redirect(ex_redirect), .md_start(md_start),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
        .idex_stall(idex_stall), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    pipe_hazard_ctrl #(.MD_CYCLES(2), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_redirect(ex_redirect), .md_start(md_start),
        .pc_stall(s_pc_stall), .ifid_stall(s_ifid_stall), .ifid_flush(s_ifid_flush),
        .idex_stall(s_idex_stall), .idex_flush(s_idex_flush), .exmem_flush(s_exmem_flush),
        .md_busy(s_md_busy), .stall_cnt(s_stall_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = '0; id_rt = '0; ex_rd = '0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        ex_memread = 1'b0; ex_redirect = 1'b0; md_start = 1'b0;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        ex_memread = 1'b1; ex_rd = rd; id_rs = rd; id_uses_rs = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_load_use(5'd8);
        ex_redirect = 1'b1;
        #2;
        n_chk++;
        if (ctrl !== C_IDLE) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected %b", ctrl, C_IDLE);
        end
        n_chk++;
        if (stall_cnt !== 16'd0) begin
            n_fail++; $display("FAIL reset_cnt: got %0d expected 0", stall_cnt);
        end
        tick();
        clear_inputs();
        rst = 1'b1;
        #2;
        n_chk++;
        if (ctrl !== C_IDLE) begin
            n_fail++; $display("FAIL reset_release_ctrl: got %b expected %b", ctrl, C_IDLE);
        end
        $display("reset: ctrl=%b stall_cnt=%0d", ctrl, stall_cnt);
        tick();
    endtask

    task automatic test_load_use();
        set_load_use(5'd8);
        #2;
        n_chk++;
        if (ctrl !== C_LU) begin
            n_fail++; $display("FAIL load_use_rs: got %b expected %b", ctrl, C_LU);
        end
        tick();
        clear_inputs();
        #2;
        n_chk++;
        if (ctrl !== C_IDLE) begin
            n_fail++; $display("FAIL load_use_after: got %b expected %b", ctrl, C_IDLE);
        end
        n_chk++;
        if (stall_cnt !== 16'd1) begin
            n_fail++; $display("FAIL load_use_cnt: got %0d expected 1", stall_cnt);
        end
        $display("load_use rs: stall_cnt=%0d", stall_cnt);
        tick();
        // rt match with a non-matching rs that is also read
        ex_memread = 1'b1; ex_rd = 5'd12; id_rs = 5'd3; id_uses_rs = 1'b1;
        id_rt = 5'd12; id_uses_rt = 1'b1;
        #2;
        n_chk++;
        if (ctrl !== C_LU) begin
            n_fail++; $display("FAIL load_use_rt: got %b expected %b", ctrl, C_LU);
        end
        tick();
        // matching rt that the instruction does not read
        id_uses_rt = 1'b0;
        #2;
        n_chk++;
        if (ctrl !== C_IDLE) begin
            n_fail++; $display("FAIL load_use_unread: got %b expected %b", ctrl, C_IDLE);
        end
        n_chk++;
        if (stall_cnt !== 16'd2) begin
            n_fail++; $display("FAIL load_use_rt_cnt: got %0d expected 2", stall_cnt);
        end
        $display("load_use rt: stall_cnt=%0d", stall_cnt);
        tick();
        clear_inputs();
    endtask

    task automatic test_load_zero();
        set_load_use(5'd0);
        id_rt = 5'd0; id_uses_rt = 1'b1;
        #2;
        n_chk++;
        if (ctrl !== C_IDLE) begin
            n_fail++; $display("FAIL load_zero_ctrl: got %b expected %b", ctrl, C_IDLE);
        end
        tick();
        clear_inputs();
        n_chk++;
        if (stall_cnt !== 16'd2) begin
            n_fail++; $display("FAIL load_zero_cnt: got %0d expected 2", stall_cnt);
        end
        $display("load_zero: stall_cnt=%0d", stall_cnt);
    endtask

    task automatic test_redirect();
        set_load_use(5'd9);
        ex_redirect = 1'b1;
        #2;
        n_chk++;
        if (ctrl !== C_RDR) begin
            n_fail++; $display("FAIL redirect_lu_ctrl: got %b expected %b", ctrl, C_RDR);
        end
        tick();
        clear_inputs();
        n_chk++;
        if (stall_cnt !== 16'd2) begin
            n_fail++; $display("FAIL redirect_lu_cnt: got %0d expected 2", stall_cnt);
        end
        // redirect beats a same-cycle md_start
        ex_redirect = 1'b1; md_start = 1'b1;
        #2;
        n_chk++;
        if (ctrl !== C_RDR) begin
            n_fail++; $display("FAIL redirect_md_ctrl: got %b expected %b", ctrl, C_RDR);
        end
        tick();
        clear_inputs();
        #2;
        n_chk++;
        if (ctrl !== C_IDLE) begin
            n_fail++; $display("FAIL redirect_md_after: got %b expected %b", ctrl, C_IDLE);
        end
        $display("redirect: stall_cnt=%0d", stall_cnt);
        tick();
    endtask

    task automatic test_mult_div();
        logic [6:0] exp_ctrl;
        int         cnt0;
        int         exp_cnt;
        cnt0 = int'(stall_cnt);
        // md_start held 5 cycles must trigger once; a redirect mid-sequence is ignored
        for (int i = 0; i < 34; i++) begin
            md_start    = (i < 5);
            ex_redirect = (i == 10);
`ifdef PIPE_MD_STALL_EN
            exp_ctrl = (i < 32) ? C_MD : C_IDLE;
`else
            exp_ctrl = (i == 10) ? C_RDR : C_IDLE;
`endif
            #2;
            n_chk++;
            if (ctrl !== exp_ctrl) begin
                n_fail++; $display("FAIL md_cycle%0d: got %b expected %b", i, ctrl, exp_ctrl);
            end
            tick();
        end
        clear_inputs();
`ifdef PIPE_MD_STALL_EN
        exp_cnt = cnt0 + 32;
`else
        exp_cnt = cnt0;
`endif
        n_chk++;
        if (int'(stall_cnt) !== exp_cnt) begin
            n_fail++; $display("FAIL md_cnt: got %0d expected %0d", stall_cnt, exp_cnt);
        end
        $display("mult_div: stall_cnt=%0d", stall_cnt);
    endtask

    task automatic test_reset_mid();
        md_start = 1'b1;
        tick();
        md_start = 1'b0;
        repeat (4) tick();
        rst = 1'b0;
        #1;
        n_chk++;
        if (ctrl !== C_IDLE) begin
            n_fail++; $display("FAIL reset_mid_ctrl: got %b expected %b", ctrl, C_IDLE);
        end
        n_chk++;
        if (stall_cnt !== 16'd0) begin
            n_fail++; $display("FAIL reset_mid_cnt: got %0d expected 0", stall_cnt);
        end
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            n_chk++;
            if (ctrl !== C_IDLE) begin
                n_fail++; $display("FAIL reset_mid_post%0d: got %b expected %b", i, ctrl, C_IDLE);
            end
            tick();
        end
        n_chk++;
        if (stall_cnt !== 16'd0) begin
            n_fail++; $display("FAIL reset_mid_post_cnt: got %0d expected 0", stall_cnt);
        end
        $display("reset_mid: ctrl=%b stall_cnt=%0d", ctrl, stall_cnt);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 21; i++) begin
            set_load_use(5'd5);
            tick();
            clear_inputs();
            tick();
            if (i == 19) begin
                n_chk++;
                if (s_stall_cnt !== 4'd15) begin
                    n_fail++; $display("FAIL sat_cnt20: got %0d expected 15", s_stall_cnt);
                end
                n_chk++;
                if (stall_cnt !== 16'd20) begin
                    n_fail++; $display("FAIL sat_wide20: got %0d expected 20", stall_cnt);
                end
            end
        end
        n_chk++;
        if (s_stall_cnt !== 4'd15) begin
            n_fail++; $display("FAIL sat_cnt21: got %0d expected 15", s_stall_cnt);
        end
        $display("saturation: narrow=%0d wide=%0d", s_stall_cnt, stall_cnt);
    endtask

    initial begin
        tick();
        test_reset();
        test_load_use();
        test_load_zero();
        test_redirect();
        test_mult_div();
        test_reset_mid();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
